instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
- Parametrised, synchronous-read instruction memory for the soft CPU; next generation of the fixed combinational program ROM.
- Contents are written at run time through a streaming load port (boot loader / debug UART bridge) instead of being hard-coded.
- After reset, a hardware init sequence fills every word with DEFAULT_INSTR before the CPU fetch port is enabled.
- Sits between the CPU fetch stage (iAddress/oInstruction) and the loader.

Parameters:
- INSTR_WIDTH, 30, instruction word width.
- ADDR_WIDTH, 16, fetch and load address width.
- DEPTH, 256, number of stored words (1..2^ADDR_WIDTH).
- DEFAULT_INSTR, 30'h000000AA, word returned for out-of-range addresses and written during init.

Ports:
- Clock  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- iAddress  input  ADDR_WIDTH  fetch address.
- oInstruction  output  INSTR_WIDTH  registered fetch data.
- oInstrValid  output  1  oInstruction holds memory data for the address presented the previous cycle.
- oReady  output  1  block is in RUN state.
- iLoadStart  input  1  single-cycle pulse; begins a load burst.
- iLoadBase  input  ADDR_WIDTH  first write address, sampled when iLoadStart is accepted.
- iLoadValid  input  1  load beat valid.
- iLoadData  input  INSTR_WIDTH  load beat data.
- iLoadLast  input  1  marks the final beat of the burst.
- oLoadReady  output  1  block accepts a beat this cycle.
- oLoadCount  output  ADDR_WIDTH+1  beats written in the current/last burst.
- oLoadError  output  1  sticky; burst overflowed DEPTH or base out of range.

Behaviour:
- Reset values: oInstruction=DEFAULT_INSTR, oInstrValid=0, oReady=0, oLoadReady=0, oLoadCount=0, oLoadError=0; state=INIT, init counter=0.
- The reset actions above happen in any state, including mid-load and mid-init, and restart INIT; all memory contents are re-cleared.
- INIT state:
  - Each cycle writes DEFAULT_INSTR to mem[counter] and increments counter.
  - After the write of DEPTH-1, go to RUN. Init therefore takes exactly DEPTH cycles after Reset deasserts; oReady=1 on cycle DEPTH+1.
  - iLoadStart is ignored.
- RUN state, fetch path:
  - Each cycle, oInstruction <= (iAddress < DEPTH) ? mem[iAddress] : DEFAULT_INSTR, and oInstrValid <= 1.
  - Latency is 1 cycle.
- RUN state, load start:
  - iLoadStart=1 with iLoadBase < DEPTH: latch wptr=iLoadBase, clear oLoadCount, clear oLoadError, go to LOAD.
  - iLoadStart=1 with iLoadBase >= DEPTH: set oLoadError=1 and stay in RUN.
- LOAD state:
  - oLoadReady=1 and oReady=0.
  - Fetch path registers oInstruction<=DEFAULT_INSTR and oInstrValid<=0.
  - A beat is accepted when iLoadValid && oLoadReady: mem[wptr]<=iLoadData, wptr++, oLoadCount++.
  - Accepted beat with iLoadLast=1: go to RUN next cycle. oLoadReady drops the cycle after the last beat.
  - Accepted beat written at wptr=DEPTH-1 without iLoadLast: the beat is written, oLoadError=1, go to RUN. Later beats are not accepted; there is no wrap-around.
  - iLoadStart during LOAD is ignored.
  - iLoadValid=0 cycles are bubbles; there is no timeout.
- oLoadCount is held after the burst ends, until the next accepted iLoadStart.
- oLoadError is cleared only by Reset or an accepted iLoadStart.
- Address compares are unsigned. If DEPTH=2^ADDR_WIDTH, out-of-range fetch never occurs.
- Memory is inferable as single-port block RAM:
  - one write port, muxed between the init and load sources;
  - one registered read port.

Test Plan:
- Reset high 2 cycles then low, DEPTH=256 -> oReady=0 for 256 cycles, 1 on the 257th; fetch of addr 5 then returns 30'h000000AA with oInstrValid=1 one cycle later.
- In RUN, iLoadStart with base=10, then beats 30'h1, 30'h2, 30'h3 (last on the third) -> oLoadCount=3, oReady returns; fetch of 10/11/12 gives 1/2/3 with 1-cycle latency; fetch of 13 gives DEFAULT_INSTR.
- Load burst with iLoadValid toggling 1,0,1,0,1 (last on the final beat) -> exactly 3 writes; oLoadReady=1 throughout; oInstrValid=0 during LOAD.
- base=254, 4 beats with no last -> words 254 and 255 written, oLoadError=1, oLoadCount=2, state RUN, third and fourth beats not accepted.
- iLoadStart with base=300 -> oLoadError=1, stays in RUN; fetch of iAddress=300 returns DEFAULT_INSTR with oInstrValid=1.
- Reset asserted after 2 beats of a burst -> all outputs return to reset values, INIT runs again for 256 cycles, and the previously loaded address reads back DEFAULT_INSTR.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - loadable synchronous-read instruction memory with hardware init
// Clears every word after reset, then serves fetches and accepts streamed load bursts.
module instr_mem_loadable #(
    parameter int                     INSTR_WIDTH   = 30,
    parameter int                     ADDR_WIDTH    = 16,
    parameter int                     DEPTH         = 256,
    parameter logic [INSTR_WIDTH-1:0] DEFAULT_INSTR = 30'h000000AA
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [ADDR_WIDTH-1:0]   iAddress,
    output logic [INSTR_WIDTH-1:0]  oInstruction,
    output logic                    oInstrValid,
    output logic                    oReady,
    input  logic                    iLoadStart,
    input  logic [ADDR_WIDTH-1:0]   iLoadBase,
    input  logic                    iLoadValid,
    input  logic [INSTR_WIDTH-1:0]  iLoadData,
    input  logic                    iLoadLast,
    output logic                    oLoadReady,
    output logic [ADDR_WIDTH:0]     oLoadCount,
    output logic                    oLoadError
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       init_cnt;
    logic [IDX_W-1:0]       wptr;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic                   we;
    logic [IDX_W-1:0]       waddr;
    logic [INSTR_WIDTH-1:0] wdata;
    logic                   beat;
    logic                   overflow;
    logic                   start_ok;
    logic                   start_bad;
    logic                   fetch_hit;
    logic                   base_ok;

    assign fetch_hit  = ({1'b0, iAddress}  < DEPTH_W);
    assign base_ok    = ({1'b0, iLoadBase} < DEPTH_W);
    assign oReady     = (state_q == ST_RUN);
    assign oLoadReady = (state_q == ST_LOAD);

    // Single write port shared by the init sweep and the load stream.
    always_comb begin
        state_d   = state_q;
        we        = 1'b0;
        waddr     = init_cnt;
        wdata     = DEFAULT_INSTR;
        beat      = 1'b0;
        overflow  = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        case (state_q)
            ST_INIT: begin
                we = 1'b1;
                if (init_cnt == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (iLoadStart) begin
                    if (base_ok) begin
                        start_ok = 1'b1;
                        state_d  = ST_LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (iLoadValid) begin
                    beat  = 1'b1;
                    we    = 1'b1;
                    waddr = wptr;
                    wdata = iLoadData;
                    if (iLoadLast) begin
                        state_d = ST_RUN;
                    end else if (wptr == LAST_IDX) begin
                        overflow = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (we && !Reset) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oInstruction <= DEFAULT_INSTR;
            oInstrValid  <= 1'b0;
        end else if (state_q == ST_RUN) begin
            oInstruction <= fetch_hit ? mem[iAddress[IDX_W-1:0]] : DEFAULT_INSTR;
            oInstrValid  <= 1'b1;
        end else begin
            oInstruction <= DEFAULT_INSTR;
            oInstrValid  <= 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            init_cnt   <= '0;
            wptr       <= '0;
            oLoadCount <= '0;
            oLoadError <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                init_cnt <= init_cnt + IDX_ONE;
            end
            if (start_ok) begin
                wptr       <= iLoadBase[IDX_W-1:0];
                oLoadCount <= '0;
                oLoadError <= 1'b0;
            end
            if (start_bad || overflow) begin
                oLoadError <= 1'b1;
            end
            if (beat) begin
                wptr       <= wptr + IDX_ONE;
                oLoadCount <= oLoadCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - self-checking bench for instr_mem_loadable
// Cycle model plus directed load/fetch scenarios with literal expectations.
module tb_instr_mem_loadable;

    localparam int IW  = 30;
    localparam int AW  = 16;
    localparam int DEP = 256;
    localparam logic [IW-1:0] DEF = 30'h000000AA;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] iAddress = '0;
    logic [IW-1:0] oInstruction;
    logic          oInstrValid;
    logic          oReady;
    logic          iLoadStart = 1'b0;
    logic [AW-1:0] iLoadBase = '0;
    logic          iLoadValid = 1'b0;
    logic [IW-1:0] iLoadData = '0;
    logic          iLoadLast = 1'b0;
    logic          oLoadReady;
    logic [AW:0]   oLoadCount;
    logic          oLoadError;

    int n_cmp = 0;
    int n_err = 0;

    instr_mem_loadable dut (
        .Clock(Clock), .Reset(Reset), .iAddress(iAddress),
        .oInstruction(oInstruction), .oInstrValid(oInstrValid), .oReady(oReady),
        .iLoadStart(iLoadStart), .iLoadBase(iLoadBase), .iLoadValid(iLoadValid),
        .iLoadData(iLoadData), .iLoadLast(iLoadLast), .oLoadReady(oLoadReady),
        .oLoadCount(oLoadCount), .oLoadError(oLoadError)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Behavioural model: memory contents plus the few facts visible at the ports.
    logic [IW-1:0] ref_mem [DEP];
    int            init_left = DEP;
    bit            loading   = 0;
    int            m_wptr    = 0;
    int            m_cnt     = 0;
    bit            m_err     = 0;
    logic [IW-1:0] m_instr   = DEF;
    bit            m_valid   = 0;
    bit            started   = 0;

    always @(posedge Clock) begin
        if (Reset) begin
            started   = 1;
            init_left = DEP;
            loading   = 0;
            m_cnt     = 0;
            m_err     = 0;
            m_instr   = DEF;
            m_valid   = 0;
            for (int i = 0; i < DEP; i++) ref_mem[i] = DEF;
        end else if (init_left > 0) begin
            init_left--;
        end else if (loading) begin
            m_instr = DEF;
            m_valid = 0;
            if (iLoadValid) begin
                ref_mem[m_wptr] = iLoadData;
                m_cnt++;
                if (iLoadLast) begin
                    loading = 0;
                end else if (m_wptr == DEP - 1) begin
                    m_err   = 1;
                    loading = 0;
                end
                m_wptr++;
            end
        end else begin
            m_instr = (int'(iAddress) < DEP) ? ref_mem[iAddress] : DEF;
            m_valid = 1;
            if (iLoadStart) begin
                if (int'(iLoadBase) < DEP) begin
                    loading = 1;
                    m_wptr  = int'(iLoadBase);
                    m_cnt   = 0;
                    m_err   = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (started) begin
            chk("instr",      32'(oInstruction), 32'(m_instr));
            chk("instr_vld",  32'(oInstrValid),  32'(m_valid));
            chk("ready",      32'(oReady),       32'(init_left == 0 && !loading));
            chk("load_ready", 32'(oLoadReady),   32'(init_left == 0 && loading));
            chk("load_count", 32'(oLoadCount),   32'(m_cnt));
            chk("load_err",   32'(oLoadError),   32'(m_err));
        end
    end

    task automatic wait_init();
        int n;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!oReady && n < 1000);
        chk("init_cycles", 32'(n), 32'd256);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        chk("rst_ready", 32'(oReady), 32'd0);
        chk("rst_instr", 32'(oInstruction), 32'(DEF));
        chk("rst_vld",   32'(oInstrValid), 32'd0);
        chk("rst_lrdy",  32'(oLoadReady), 32'd0);
        chk("rst_cnt",   32'(oLoadCount), 32'd0);
        chk("rst_err",   32'(oLoadError), 32'd0);
        Reset = 1'b0;
        wait_init();
    endtask

    task automatic fetch(input int addr, input logic [IW-1:0] exp);
        iAddress = AW'(addr);
        @(negedge Clock);
        chk($sformatf("fetch_%0d", addr), 32'(oInstruction), 32'(exp));
        chk($sformatf("fetch_vld_%0d", addr), 32'(oInstrValid), 32'd1);
    endtask

    task automatic start(input int base);
        iLoadStart = 1'b1;
        iLoadBase  = AW'(base);
        @(negedge Clock);
        iLoadStart = 1'b0;
    endtask

    task automatic beat(input bit v, input logic [IW-1:0] d, input bit last);
        iLoadValid = v;
        iLoadData  = d;
        iLoadLast  = last;
        @(negedge Clock);
        iLoadValid = 1'b0;
        iLoadLast  = 1'b0;
    endtask

    initial begin
        @(negedge Clock);
        do_reset();
        fetch(5, DEF);

        start(10);
        beat(1, 30'h1, 0);
        beat(1, 30'h2, 0);
        beat(1, 30'h3, 1);
        chk("burst1_cnt", 32'(oLoadCount), 32'd3);
        chk("burst1_rdy", 32'(oReady), 32'd1);
        fetch(10, 30'h1);
        fetch(11, 30'h2);
        fetch(12, 30'h3);
        fetch(13, DEF);

        start(20);
        chk("bubble_lrdy", 32'(oLoadReady), 32'd1);
        beat(1, 30'h7, 0);
        beat(0, 30'h3FF, 0);
        beat(1, 30'h8, 0);
        beat(0, 30'h3FF, 0);
        beat(1, 30'h9, 1);
        chk("burst2_cnt", 32'(oLoadCount), 32'd3);
        fetch(20, 30'h7);
        fetch(21, 30'h8);
        fetch(22, 30'h9);
        fetch(23, DEF);

        start(300);
        chk("badbase_err", 32'(oLoadError), 32'd1);
        chk("badbase_rdy", 32'(oReady), 32'd1);
        fetch(300, DEF);

        start(30);
        beat(1, 30'h2A, 1);
        chk("err_cleared", 32'(oLoadError), 32'd0);
        fetch(30, 30'h2A);

        start(254);
        beat(1, 30'h100, 0);
        beat(1, 30'h101, 0);
        beat(1, 30'h102, 0);
        beat(1, 30'h103, 0);
        chk("ovf_err", 32'(oLoadError), 32'd1);
        chk("ovf_cnt", 32'(oLoadCount), 32'd2);
        chk("ovf_rdy", 32'(oReady), 32'd1);
        fetch(254, 30'h100);
        fetch(255, 30'h101);
        fetch(0, DEF);

        start(40);
        beat(1, 30'h5, 0);
        beat(1, 30'h6, 0);
        do_reset();
        fetch(40, DEF);
        fetch(10, DEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
